// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between the instruction-fetch (I)
// and load/store (D) requesters, with a registered handshake and a bus-timeout abort.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ack_o,
    output logic              i_err_o,
    output logic              i_wait_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic              d_byte_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              d_err_o,
    output logic              d_wait_o,

    output logic              m_req_o,
    output logic              m_we_o,
    output logic              m_byte_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_ack_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic              m_byte_q, m_byte_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              i_err_q, i_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic              d_err_q, d_err_d;

    logic              i_elig_s;
    logic              d_elig_s;
    logic              pick_i_s;
    logic              pick_d_s;
    logic              timeout_s;
    logic [DATA_W-1:0] done_rdata_s;

    // A requester being acked this cycle is still holding req and must not be re-granted.
    assign i_elig_s  = i_req_i & ~i_ack_q;
    assign d_elig_s  = d_req_i & ~d_ack_q;
    assign pick_i_s  = i_elig_s & (~d_elig_s | (last_grant_q == GRANT_D));
    assign pick_d_s  = d_elig_s & ~pick_i_s;
    assign timeout_s = TO_EN && (cnt_q == CNT_LAST) && !m_ack_i;

    // Completion data: memory data on ack, all ones on abort (ack has priority).
    assign done_rdata_s = m_ack_i ? m_rdata_i : {DATA_W{1'b1}};

    // Next-state and registered-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_byte_d     = m_byte_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_i_s) begin
                    state_d      = BUSY_I;
                    last_grant_d = GRANT_I;
                    cnt_d        = {CNT_W{1'b0}};
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_byte_d     = 1'b0;
                    m_addr_d     = i_addr_i;
                    m_wdata_d    = {DATA_W{1'b0}};
                end else if (pick_d_s) begin
                    state_d      = BUSY_D;
                    last_grant_d = GRANT_D;
                    cnt_d        = {CNT_W{1'b0}};
                    m_req_d      = 1'b1;
                    m_we_d       = d_we_i;
                    m_byte_d     = d_byte_i;
                    m_addr_d     = d_addr_i;
                    m_wdata_d    = d_wdata_i;
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY_I, BUSY_D: begin
                if (m_ack_i || timeout_s) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_rdata_d = done_rdata_s;
                        i_ack_d   = 1'b1;
                        i_err_d   = ~m_ack_i;
                    end else begin
                        d_rdata_d = done_rdata_s;
                        d_ack_d   = 1'b1;
                        d_err_d   = ~m_ack_i;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            cnt_q        <= {CNT_W{1'b0}};
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_byte_q     <= 1'b0;
            m_addr_q     <= {ADDR_W{1'b0}};
            m_wdata_q    <= {DATA_W{1'b0}};
            i_rdata_q    <= {DATA_W{1'b0}};
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= {DATA_W{1'b0}};
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_byte_q     <= m_byte_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_rdata_q    <= i_rdata_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
        end
    end

    assign m_req_o   = m_req_q;
    assign m_we_o    = m_we_q;
    assign m_byte_o  = m_byte_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign i_rdata_o = i_rdata_q;
    assign i_ack_o   = i_ack_q;
    assign i_err_o   = i_err_q;
    assign d_rdata_o = d_rdata_q;
    assign d_ack_o   = d_ack_q;
    assign d_err_o   = d_err_q;

    // Wait is combinational so the core stalls exactly until its ack cycle.
    assign i_wait_o  = i_req_i & ~i_ack_q;
    assign d_wait_o  = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected memory transactions and
// requester responses; a memory responder and an ack monitor pop and compare.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ack, i_err, i_wait;
    logic        d_req, d_we, d_byte;
    logic [15:0] d_addr, d_wdata, d_rdata;
    logic        d_ack, d_err, d_wait;
    logic        m_req, m_we, m_byte;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata;
    logic        m_ack;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata),
        .i_ack_o(i_ack), .i_err_o(i_err), .i_wait_o(i_wait),
        .d_req_i(d_req), .d_we_i(d_we), .d_byte_i(d_byte), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ack_o(d_ack), .d_err_o(d_err),
        .d_wait_o(d_wait),
        .m_req_o(m_req), .m_we_o(m_we), .m_byte_o(m_byte), .m_addr_o(m_addr),
        .m_wdata_o(m_wdata), .m_rdata_i(m_rdata), .m_ack_i(m_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        bw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;   // wait cycles before m_ack; negative means never ack
        int          hi;    // expected m_req high cycles when never acked
    } mtx_t;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;

    mtx_t mem_q[$];
    rsp_t exp_i[$];
    rsp_t exp_d[$];
    int   total = 0;
    int   bad = 0;
    int   spur_req = 0;
    int   spur_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic bw, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata,
                            input int lat, input int hi);
        mtx_t t;
        t.we = we; t.bw = bw; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.lat = lat; t.hi = hi;
        mem_q.push_back(t);
    endtask

    task automatic push_rsp(input logic is_d, input logic [15:0] rdata, input logic err);
        rsp_t r;
        r.rdata = rdata; r.err = err;
        if (is_d) exp_d.push_back(r);
        else      exp_i.push_back(r);
    endtask

    // I requester: keeps req high across ntx back-to-back transfers.
    task automatic hs_i(input int ntx, input logic [15:0] addr0);
        int n;
        i_addr = addr0;
        i_req  = 1'b1;
        for (int k = 0; k < ntx; k++) begin
            n = 0;
            @(negedge clk);
            while (!i_ack && n < 50) begin
                chk("i_wait", 32'(i_wait), 32'd1);
                @(negedge clk);
                n++;
            end
            if (!i_ack) begin
                total++; bad++;
                $display("FAIL i_ack timeout: got no ack in 50 cycles, required ack");
            end else begin
                chk("i_wait at ack", 32'(i_wait), 32'd0);
            end
            i_addr = addr0 + 16'(k + 1) * 16'h0010;
        end
        i_req = 1'b0;
    endtask

    task automatic hs_d(input int ntx, input logic [15:0] addr0, input logic we,
                        input logic bw, input logic [15:0] wdata);
        int n;
        d_addr = addr0; d_we = we; d_byte = bw; d_wdata = wdata;
        d_req  = 1'b1;
        for (int k = 0; k < ntx; k++) begin
            n = 0;
            @(negedge clk);
            while (!d_ack && n < 50) begin
                chk("d_wait", 32'(d_wait), 32'd1);
                @(negedge clk);
                n++;
            end
            if (!d_ack) begin
                total++; bad++;
                $display("FAIL d_ack timeout: got no ack in 50 cycles, required ack");
            end else begin
                chk("d_wait at ack", 32'(d_wait), 32'd0);
            end
            d_addr = addr0 + 16'(k + 1) * 16'h0010;
        end
        d_req = 1'b0;
    endtask

    // Memory model: checks each granted transfer and answers with the scripted latency.
    initial begin : responder
        mtx_t t;
        int   n;
        m_ack   = 1'b0;
        m_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (m_req) begin
                if (mem_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected m_req: got m_req=1 addr=%0h required none", m_addr);
                    n = 0;
                    while (m_req && n < 64) begin @(negedge clk); n++; end
                end else begin
                    t = mem_q.pop_front();
                    chk("m_addr", 32'(m_addr), 32'(t.addr));
                    chk("m_we/m_byte", 32'({m_we, m_byte}), 32'({t.we, t.bw}));
                    chk("m_wdata", 32'(m_wdata), 32'(t.wdata));
                    if (t.lat >= 0) begin
                        for (int k = 0; k < t.lat; k++) begin
                            @(negedge clk);
                            chk("m_req held", 32'({m_req, m_addr}), 32'({1'b1, t.addr}));
                        end
                        m_ack   = 1'b1;
                        m_rdata = t.rdata;
                        @(negedge clk);
                        m_ack   = 1'b0;
                        m_rdata = 16'h0000;
                        chk("dead cycle m_req", 32'(m_req), 32'd0);
                    end else begin
                        n = 1;
                        while (n < 64) begin
                            @(negedge clk);
                            if (!m_req) break;
                            n++;
                        end
                        chk("m_req high cycles", 32'(n), 32'(t.hi));
                    end
                end
            end else if (spur_req != spur_done) begin
                m_ack   = 1'b1;
                m_rdata = 16'hDEAD;
                @(negedge clk);
                m_ack   = 1'b0;
                m_rdata = 16'h0000;
                spur_done++;
            end
        end
    end

    // Ack monitor: every ack must match the next expected response of that requester.
    initial begin : monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (i_ack) begin
                if (exp_i.size() == 0) begin
                    total++; bad++;
                    $display("FAIL i_ack unexpected: got ack=1 rdata=%0h required ack=0", i_rdata);
                end else begin
                    r = exp_i.pop_front();
                    chk("i_rdata", 32'(i_rdata), 32'(r.rdata));
                    chk("i_err", 32'(i_err), 32'(r.err));
                end
            end else begin
                chk("i_err without ack", 32'(i_err), 32'd0);
            end
            if (d_ack) begin
                if (exp_d.size() == 0) begin
                    total++; bad++;
                    $display("FAIL d_ack unexpected: got ack=1 rdata=%0h required ack=0", d_rdata);
                end else begin
                    r = exp_d.pop_front();
                    chk("d_rdata", 32'(d_rdata), 32'(r.rdata));
                    chk("d_err", 32'(d_err), 32'(r.err));
                end
            end else begin
                chk("d_err without ack", 32'(d_err), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1; i_req = 1'b0; i_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset ctrl", 32'({m_req, m_we, m_byte, i_ack, i_err, d_ack, d_err}), 32'd0);
        chk("reset m_addr/m_wdata", {m_addr, m_wdata}, 32'd0);
        chk("reset rdata", {i_rdata, d_rdata}, 32'd0);
        rst = 1'b0;

        // single instruction read, m_ack three cycles into m_req
        push_mem(1'b0, 1'b0, 16'h0100, 16'h0000, 16'hBEEF, 2, 0);
        push_rsp(1'b0, 16'hBEEF, 1'b0);
        hs_i(1, 16'h0100);

        // byte write; write data comes back as passed-through m_rdata
        push_mem(1'b1, 1'b1, 16'h2001, 16'h00A5, 16'h1234, 1, 0);
        push_rsp(1'b1, 16'h1234, 1'b0);
        hs_d(1, 16'h2001, 1'b1, 1'b1, 16'h00A5);

        // timeout abort, then ack exactly on the timeout cycle
        push_mem(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h0000, -1, 4);
        push_rsp(1'b1, 16'hFFFF, 1'b1);
        hs_d(1, 16'h3000, 1'b0, 1'b0, 16'h0000);
        push_mem(1'b0, 1'b0, 16'h3002, 16'h0000, 16'h5A5A, 3, 0);
        push_rsp(1'b1, 16'h5A5A, 1'b0);
        hs_d(1, 16'h3002, 1'b0, 1'b0, 16'h0000);

        // spurious m_ack while idle leaves every output alone
        repeat (2) @(negedge clk);
        spur_req++;
        repeat (4) @(negedge clk);
        chk("spurious i_rdata", 32'(i_rdata), 32'h0000BEEF);
        chk("spurious d_rdata", 32'(d_rdata), 32'h00005A5A);
        chk("spurious m_req", 32'(m_req), 32'd0);

        // I withdraws its request mid-transfer; ack still pulses once
        push_mem(1'b0, 1'b0, 16'h0400, 16'h0000, 16'h7777, 2, 0);
        push_rsp(1'b0, 16'h7777, 1'b0);
        i_addr = 16'h0400;
        i_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        i_req = 1'b0;
        n = 0;
        while (!i_ack && n < 20) begin @(negedge clk); n++; end
        chk("withdrawn i_ack", 32'(i_ack), 32'd1);
        repeat (3) @(negedge clk);

        // reset while BUSY_D: transfer abandoned, no ack
        push_mem(1'b0, 1'b0, 16'h6000, 16'h0000, 16'h0000, -1, 1);
        d_addr = 16'h6000; d_we = 1'b0; d_byte = 1'b0; d_wdata = 16'h0000;
        d_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_req && n < 20);
        rst   = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("reset mid-op m_req", 32'(m_req), 32'd0);
        chk("reset mid-op d_ack", 32'(d_ack), 32'd0);
        chk("reset mid-op rdata", {i_rdata, d_rdata}, 32'd0);
        @(negedge clk);

        // both request together: I first after reset, then strict alternation
        push_mem(1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h1111, 0, 0);
        push_mem(1'b0, 1'b0, 16'h0B00, 16'h0000, 16'h2222, 1, 0);
        push_mem(1'b0, 1'b0, 16'h0A10, 16'h0000, 16'h3333, 2, 0);
        push_mem(1'b0, 1'b0, 16'h0B10, 16'h0000, 16'h4444, 0, 0);
        push_rsp(1'b0, 16'h1111, 1'b0);
        push_rsp(1'b0, 16'h3333, 1'b0);
        push_rsp(1'b1, 16'h2222, 1'b0);
        push_rsp(1'b1, 16'h4444, 1'b0);
        fork
            hs_i(2, 16'h0A00);
            hs_d(2, 16'h0B00, 1'b0, 1'b0, 16'h0000);
        join

        repeat (5) @(negedge clk);
        chk("mem queue drained", 32'(mem_q.size()), 32'd0);
        chk("i responses drained", 32'(exp_i.size()), 32'd0);
        chk("d responses drained", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
